// File: rtl/dbg_scan_pkg.sv
// dbg_scan_pkg
// Shared types and constants for the debug register-file scanner.
// The optional CKSUM state exists only when DBG_SCAN_CHECKSUM_EN is defined.
package dbg_scan_pkg;

    localparam int NUM_REGS = 32;
    localparam int LAST_IDX = NUM_REGS - 1;

    typedef logic [4:0] reg_idx_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_SEND,
`ifdef DBG_SCAN_CHECKSUM_EN
        ST_CKSUM,
`endif
        ST_DONE
    } scan_state_t;

endpackage

// File: rtl/dbg_settle_cnt.sv
// dbg_settle_cnt
// Counts the cycles reg_sel has been held so the CPU read port can settle.
// Ports:
//   clk, rstn : clock, asynchronous active-low reset
//   load      : reload the counter with SETTLE_CYCLES (entering SELECT)
//   en        : counting enable (high while in SELECT)
//   expired   : high in the last settle cycle; reg_data is sampled at the next edge
module dbg_settle_cnt #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic clk,
    input  logic rstn,
    input  logic load,
    input  logic en,
    output logic expired
);

    logic [3:0] count;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count <= '0;
        end else if (load) begin
            count <= 4'(SETTLE_CYCLES);
        end else if (en && count != 4'd0) begin
            count <= count - 4'd1;
        end
    end

    // Expiring on count==1 makes SELECT last exactly SETTLE_CYCLES cycles.
    assign expired = en && (count == 4'd1);

endmodule

// File: rtl/dbg_reg_scanner.sv
// dbg_reg_scanner
// Walks the CPU debug read port over all 32 registers and streams each value
// out through a valid/ready interface.
// Optional feature: define DBG_SCAN_CHECKSUM_EN to append one XOR checksum
// word (out_idx=0, out_last=1) after register 31.
// Ports:
//   clk, rstn           : clock, asynchronous active-low reset
//   start, abort        : begin a scan / abandon the scan in progress
//   busy, done          : scan in progress / one-cycle completion pulse
//   reg_sel, reg_data   : CPU debug read port (index out, value in)
//   out_valid/out_ready : output handshake
//   out_idx, out_data   : register index and value of the current word
//   out_last            : final word of the scan
module dbg_reg_scanner
    import dbg_scan_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int SKIP_X0       = 0
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic        abort,
    output logic        busy,
    output logic [4:0]  reg_sel,
    input  logic [31:0] reg_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_idx,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic        done
);

    scan_state_t state;
    scan_state_t state_nxt;
    reg_idx_t    idx;
    logic        settle_expired;
    logic        settle_load;
    logic        last_word;
`ifdef DBG_SCAN_CHECKSUM_EN
    logic [31:0] cksum;
`endif

    assign last_word = (idx == reg_idx_t'(LAST_IDX));

    // reg_sel only changes when idx changes, which happens only on entry to
    // SELECT, so it naturally holds its value in every other state.
    assign reg_sel = idx;

    assign settle_load = ((state == ST_IDLE) && start) ||
                         ((state == ST_SEND) && !abort && out_ready && !last_word);

    dbg_settle_cnt #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_settle (
        .clk    (clk),
        .rstn   (rstn),
        .load   (settle_load),
        .en     (state == ST_SELECT),
        .expired(settle_expired)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Abort beats everything outside IDLE; in IDLE start beats abort.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (settle_expired) begin
                    state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (out_ready) begin
`ifdef DBG_SCAN_CHECKSUM_EN
                    state_nxt = last_word ? ST_CKSUM : ST_SELECT;
`else
                    state_nxt = last_word ? ST_DONE : ST_SELECT;
`endif
                end
            end
`ifdef DBG_SCAN_CHECKSUM_EN
            ST_CKSUM: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (out_ready) begin
                    state_nxt = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        busy      = (state != ST_IDLE);
        done      = (state == ST_DONE);
        out_valid = 1'b0;
        out_last  = 1'b0;
        case (state)
            ST_SEND: begin
                out_valid = 1'b1;
`ifdef DBG_SCAN_CHECKSUM_EN
                out_last  = 1'b0;
`else
                out_last  = (out_idx == reg_idx_t'(LAST_IDX));
`endif
            end
`ifdef DBG_SCAN_CHECKSUM_EN
            ST_CKSUM: begin
                out_valid = 1'b1;
                out_last  = 1'b1;
            end
`endif
            default: begin
                out_valid = 1'b0;
                out_last  = 1'b0;
            end
        endcase
    end

    // Index and captured word. idx saturates at the last register rather than
    // wrapping, so reg_sel still shows 31 after the scan ends.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idx      <= '0;
            out_idx  <= '0;
            out_data <= '0;
`ifdef DBG_SCAN_CHECKSUM_EN
            cksum    <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        idx   <= reg_idx_t'(SKIP_X0);
`ifdef DBG_SCAN_CHECKSUM_EN
                        cksum <= '0;
`endif
                    end
                end
                ST_SELECT: begin
                    if (!abort && settle_expired) begin
                        out_data <= reg_data;
                        out_idx  <= idx;
`ifdef DBG_SCAN_CHECKSUM_EN
                        cksum    <= cksum ^ reg_data;
`endif
                    end
                end
                ST_SEND: begin
                    if (!abort && out_ready) begin
                        if (!last_word) begin
                            idx <= idx + 5'd1;
                        end
`ifdef DBG_SCAN_CHECKSUM_EN
                        else begin
                            out_data <= cksum;
                            out_idx  <= '0;
                        end
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dbg_reg_scanner.sv
// tb_dbg_reg_scanner
// Drives two scanner instances (A: defaults, B: SKIP_X0=1 / SETTLE_CYCLES=3)
// and compares every streamed word against a word list computed directly
// from the register-file contents.
module tb_dbg_reg_scanner;
    import dbg_scan_pkg::*;

    localparam int SETTLE_A = 1;
    localparam int SKIP_A   = 0;
    localparam int SETTLE_B = 3;
    localparam int SKIP_B   = 1;
`ifdef DBG_SCAN_CHECKSUM_EN
    localparam bit CKSUM_EN = 1'b1;
`else
    localparam bit CKSUM_EN = 1'b0;
`endif

    typedef struct packed {
        logic [4:0]  idx;
        logic [31:0] data;
        logic        last;
        logic [4:0]  sel;
        logic        is_cksum;
    } word_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        start_a = 1'b0;
    logic        start_b = 1'b0;
    logic        abort = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] regfile [NUM_REGS];

    logic        busy_a, out_valid_a, out_last_a, done_a;
    logic [4:0]  reg_sel_a, out_idx_a;
    logic [31:0] reg_data_a, out_data_a;
    logic        busy_b, out_valid_b, out_last_b, done_b;
    logic [4:0]  reg_sel_b, out_idx_b;
    logic [31:0] reg_data_b, out_data_b;

    logic        use_b = 1'b0;
    logic        obs_busy, obs_valid, obs_last, obs_done;
    logic [4:0]  obs_sel, obs_idx;
    logic [31:0] obs_data;

    int          n_checks = 0;
    int          n_failed = 0;
    word_t       exp_q[$];

    assign reg_data_a = regfile[reg_sel_a];
    assign reg_data_b = regfile[reg_sel_b];

    always #5 clk = ~clk;

    dbg_reg_scanner #(.SETTLE_CYCLES(SETTLE_A), .SKIP_X0(SKIP_A)) dut_a (
        .clk(clk), .rstn(rstn), .start(start_a), .abort(abort), .busy(busy_a),
        .reg_sel(reg_sel_a), .reg_data(reg_data_a), .out_valid(out_valid_a),
        .out_ready(out_ready), .out_idx(out_idx_a), .out_data(out_data_a),
        .out_last(out_last_a), .done(done_a)
    );

    dbg_reg_scanner #(.SETTLE_CYCLES(SETTLE_B), .SKIP_X0(SKIP_B)) dut_b (
        .clk(clk), .rstn(rstn), .start(start_b), .abort(abort), .busy(busy_b),
        .reg_sel(reg_sel_b), .reg_data(reg_data_b), .out_valid(out_valid_b),
        .out_ready(out_ready), .out_idx(out_idx_b), .out_data(out_data_b),
        .out_last(out_last_b), .done(done_b)
    );

    always_comb begin
        obs_busy  = use_b ? busy_b      : busy_a;
        obs_valid = use_b ? out_valid_b : out_valid_a;
        obs_last  = use_b ? out_last_b  : out_last_a;
        obs_done  = use_b ? done_b      : done_a;
        obs_sel   = use_b ? reg_sel_b   : reg_sel_a;
        obs_idx   = use_b ? out_idx_b   : out_idx_a;
        obs_data  = use_b ? out_data_b  : out_data_a;
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_failed++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Expected stream: one word per register from the first index, then the
    // XOR of every emitted word when the checksum feature is built in.
    function automatic void build_expected(input int first);
        logic [31:0] acc;
        acc = '0;
        exp_q.delete();
        for (int i = first; i < NUM_REGS; i++) begin
            acc ^= regfile[i];
            exp_q.push_back('{idx: 5'(i), data: regfile[i],
                              last: (i == NUM_REGS - 1) && !CKSUM_EN,
                              sel: 5'(i), is_cksum: 1'b0});
        end
        if (CKSUM_EN) begin
            exp_q.push_back('{idx: 5'd0, data: acc, last: 1'b1,
                              sel: 5'(NUM_REGS - 1), is_cksum: 1'b1});
        end
    endfunction

    task automatic fill_regs(input int mode);
        for (int i = 0; i < NUM_REGS; i++) begin
            case (mode)
                0:       regfile[i] = 32'h1000_0000 + 32'(i);
                1:       regfile[i] = 32'(i);
                default: regfile[i] = $urandom;
            endcase
        end
    endtask

    task automatic check_reset_outputs(input string who, input logic busy, input logic valid,
                                       input logic [4:0] sel, input logic [4:0] idx,
                                       input logic [31:0] data, input logic last, input logic dn);
        check_output({who, "_busy"},    32'(busy),  32'd0);
        check_output({who, "_valid"},   32'(valid), 32'd0);
        check_output({who, "_reg_sel"}, 32'(sel),   32'd0);
        check_output({who, "_out_idx"}, 32'(idx),   32'd0);
        check_output({who, "_out_data"}, data,      32'd0);
        check_output({who, "_out_last"}, 32'(last), 32'd0);
        check_output({who, "_done"},    32'(dn),    32'd0);
    endtask

    // One scan: pulses start at a negedge, then samples every negedge, checks
    // the presented word against the expected list and decides out_ready.
    task automatic apply_stimulus(input bit on_b, input int ready_pct, input int stall_idx,
                                  input int stall_len, input int abort_idx,
                                  input bit start_glitch, input bit start_with_abort,
                                  output int n_words);
        int    cycle, words, stalled, last_hs, settle, first;
        bit    finished, ready, glitched, aborting, exp_done;
        word_t w;
        cycle = 0; words = 0; stalled = 0; last_hs = -10;
        finished = 0; glitched = 0; aborting = 0;
        settle = on_b ? SETTLE_B : SETTLE_A;
        first  = on_b ? SKIP_B : SKIP_A;
        use_b  = on_b;
        build_expected(first);
        if (on_b) start_b = 1'b1; else start_a = 1'b1;
        abort = start_with_abort;
        @(negedge clk);
        start_a = 1'b0; start_b = 1'b0; abort = 1'b0;
        check_output("busy_after_start", 32'(obs_busy), 32'd1);
        check_output("reg_sel_first", 32'(obs_sel), 32'(first));
        while (!finished) begin
            start_a = 1'b0; start_b = 1'b0;
            if (aborting) begin
                abort = 1'b0;
                check_output("abort_busy", 32'(obs_busy), 32'd0);
                check_output("abort_valid", 32'(obs_valid), 32'd0);
                repeat (4) begin
                    @(negedge clk);
                    check_output("abort_no_done", 32'(obs_done), 32'd0);
                end
                finished = 1;
            end else if (cycle > 2000) begin
                check_output("scan_timeout", 32'(words), 32'(exp_q.size()));
                finished = 1;
            end else begin
                exp_done = (words == exp_q.size()) && (last_hs == cycle - 1);
                check_output("done", 32'(obs_done), 32'(exp_done));
                if (exp_done) begin
                    @(negedge clk);
                    check_output("busy_after_done", 32'(obs_busy), 32'd0);
                    finished = 1;
                end else if (obs_valid && words >= exp_q.size()) begin
                    check_output("extra_word", 32'(words), 32'(exp_q.size()));
                    finished = 1;
                end else begin
                    ready = ($urandom_range(99) < ready_pct);
                    if (obs_valid) begin
                        w = exp_q[words];
                        check_output("out_idx", 32'(obs_idx), 32'(w.idx));
                        check_output("out_data", obs_data, w.data);
                        check_output("out_last", 32'(obs_last), 32'(w.last));
                        check_output("reg_sel_hold", 32'(obs_sel), 32'(w.sel));
                        if (!w.is_cksum && int'(w.idx) == stall_idx && stalled < stall_len) begin
                            ready = 1'b0;
                            stalled++;
                        end
                        if (start_glitch && !glitched && !w.is_cksum && w.idx == 5'd3) begin
                            if (on_b) start_b = 1'b1; else start_a = 1'b1;
                            glitched = 1;
                        end
                        if (!w.is_cksum && int'(w.idx) == abort_idx) begin
                            abort = 1'b1;
                            aborting = 1;
                        end
                        if (ready) begin
                            if (ready_pct == 100 && stall_len == 0 && words > 0 && !w.is_cksum) begin
                                check_output("throughput_gap", 32'(cycle - last_hs), 32'(settle + 1));
                            end
                            last_hs = cycle;
                            words++;
                        end
                    end
                    out_ready = ready;
                    @(negedge clk);
                    cycle++;
                end
            end
        end
        out_ready = 1'b0;
        n_words = words;
    endtask

    initial begin
        int n;
        fill_regs(0);
        #2 rstn = 1'b0;
        #1;
        check_reset_outputs("rst_a", busy_a, out_valid_a, reg_sel_a, out_idx_a, out_data_a, out_last_a, done_a);
        check_reset_outputs("rst_b", busy_b, out_valid_b, reg_sel_b, out_idx_b, out_data_b, out_last_b, done_b);
        #24 rstn = 1'b1;
        @(negedge clk);

        $display("[TB] full scan, incrementing data, ready held high");
        apply_stimulus(0, 100, -1, 0, -1, 0, 0, n);
        check_output("count_full", 32'(n), 32'(NUM_REGS + int'(CKSUM_EN)));

        $display("[TB] stall 7 cycles on idx 5, start pulsed while busy");
        apply_stimulus(0, 100, 5, 7, -1, 1, 0, n);
        check_output("count_stall", 32'(n), 32'(NUM_REGS + int'(CKSUM_EN)));

        $display("[TB] abort at idx 10, then restart with start+abort together");
        apply_stimulus(0, 100, -1, 0, 10, 0, 0, n);
        check_output("count_abort", 32'(n), 32'd11);
        fill_regs(2);
        apply_stimulus(0, 60, -1, 0, -1, 0, 1, n);
        check_output("count_restart", 32'(n), 32'(NUM_REGS + int'(CKSUM_EN)));

        $display("[TB] SKIP_X0 instance, random data");
        fill_regs(2);
        apply_stimulus(1, 100, -1, 0, -1, 0, 0, n);
        check_output("count_skip", 32'(n), 32'(NUM_REGS - 1 + int'(CKSUM_EN)));
        fill_regs(2);
        apply_stimulus(1, 50, 20, 3, -1, 0, 0, n);
        check_output("count_skip_rand", 32'(n), 32'(NUM_REGS - 1 + int'(CKSUM_EN)));

        $display("[TB] asynchronous reset mid-scan");
        use_b = 1'b0;
        out_ready = 1'b1;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (21) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        check_reset_outputs("midrst_a", busy_a, out_valid_a, reg_sel_a, out_idx_a, out_data_a, out_last_a, done_a);
        @(negedge clk);
        #2 rstn = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);

        $display("[TB] scan with reg_data equal to index");
        fill_regs(1);
        apply_stimulus(0, 100, -1, 0, -1, 0, 0, n);
        check_output("count_xor", 32'(n), 32'(NUM_REGS + int'(CKSUM_EN)));

        $display("%0d/%0d checks passed", n_checks - n_failed, n_checks);
        $finish;
    end

endmodule
